// File: rtl/vend_pkg.sv
// Shared types, price table and helpers
// for the vending machine controller.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE,
    S_ERROR
  } state_t;

  localparam int CREDIT_W  = 8;
  localparam int ROW_MAX   = 7;
  localparam int DIGIT_MAX = 9;

  typedef logic [CREDIT_W-1:0] cents_t;

  // index 0 is the rightmost entry
  localparam logic [7:0][CREDIT_W-1:0] PRICE_TABLE = {
    8'd200, 8'd150, 8'd150, 8'd125,
    8'd100, 8'd100, 8'd75,  8'd50
  };

  function automatic logic code_valid(
    input logic [11:0] c
  );
    return (c[3:0]  <= 4'(ROW_MAX))
        && (c[7:4]  <= 4'(DIGIT_MAX))
        && (c[11:8] <= 4'(DIGIT_MAX));
  endfunction

  function automatic cents_t sat_add(
    input cents_t a,
    input cents_t b
  );
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CREDIT_W] ? '1
                         : sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/vend_machine_controller_if.sv
// Keypad, coin and vend signals between
// the front panel and the controller.
interface vend_machine_controller_if;
  import vend_pkg::*;

  logic         check_price;
  logic [11:0]  concat_press;
  logic         coin_valid;
  cents_t       coin_value;
  logic         cancel;
  logic         busy;
  logic         clear;
  logic         dispense;
  logic [11:0]  dispense_code;
  logic         change_valid;
  cents_t       change_amount;
  logic         invalid_code;
  logic         coin_reject;
  cents_t       credit;
  logic [31:0]  cycles;

  modport master (
    output check_price, concat_press,
    output coin_valid, coin_value, cancel,
    input  busy, clear, dispense,
    input  dispense_code, change_valid,
    input  change_amount, invalid_code,
    input  coin_reject, credit, cycles
  );

  modport slave (
    input  check_price, concat_press,
    input  coin_valid, coin_value, cancel,
    output busy, clear, dispense,
    output dispense_code, change_valid,
    output change_amount, invalid_code,
    output coin_reject, credit, cycles
  );

endinterface

// File: rtl/vend_price_rom.sv
// Registered price lookup: row selects
// the price, the whole code is validated.
module vend_price_rom
  import vend_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [11:0] code,
  output cents_t      price,
  output logic        code_ok
);

  // capture price and validity when a code is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      price   <= '0;
      code_ok <= 1'b0;
    end else if (en) begin
      price   <= PRICE_TABLE[code[2:0]];
      code_ok <= code_valid(code);
    end
  end

endmodule

// File: rtl/vend_machine_controller.sv
// Vending controller: code lookup, coin
// collection, vend, change and refunds.
module vend_machine_controller
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  vend_machine_controller_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1)
                    ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t       state;
  logic [11:0]  code_q;
  cents_t       price_q;
  cents_t       credit_q;
  logic [TW-1:0] tmo;
  logic [31:0]  cycles_q;

  logic         busy_q;
  logic         clear_q;
  logic         dispense_q;
  logic [11:0]  dcode_q;
  logic         chg_v_q;
  cents_t       chg_amt_q;
  logic         inv_q;
  logic         rej_q;

  logic         rom_en;
  cents_t       rom_price;
  logic         rom_ok;
  cents_t       coin_sum;
  cents_t       credit_in;
  logic         expired;

  assign rom_en = (state == S_IDLE)
               && bus.check_price;

  vend_price_rom u_rom (
    .clk     (clk),
    .reset   (reset),
    .en      (rom_en),
    .code    (bus.concat_press),
    .price   (rom_price),
    .code_ok (rom_ok)
  );

  assign coin_sum  = sat_add(credit_q,
                             bus.coin_value);
  assign credit_in = bus.coin_valid ? coin_sum
                                    : credit_q;
  assign expired   = !bus.coin_valid
    && (tmo == TW'(TIMEOUT_CYCLES - 1));

  // transaction FSM with registered strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      code_q     <= '0;
      price_q    <= '0;
      credit_q   <= '0;
      tmo        <= '0;
      cycles_q   <= '0;
      busy_q     <= 1'b0;
      clear_q    <= 1'b0;
      dispense_q <= 1'b0;
      dcode_q    <= '0;
      chg_v_q    <= 1'b0;
      chg_amt_q  <= '0;
      inv_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      cycles_q   <= cycles_q + 32'd1;
      clear_q    <= 1'b0;
      dispense_q <= 1'b0;
      chg_v_q    <= 1'b0;
      inv_q      <= 1'b0;
      rej_q      <= bus.coin_valid
                 && (state != S_COLLECT);
      unique case (state)
        S_IDLE: begin
          if (bus.check_price) begin
            code_q <= bus.concat_press;
            state  <= S_LOOKUP;
            busy_q <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (rom_ok) begin
            price_q <= rom_price;
            tmo     <= '0;
            state   <= S_COLLECT;
          end else begin
            state   <= S_ERROR;
          end
        end
        S_ERROR: begin
          inv_q   <= 1'b1;
          clear_q <= 1'b1;
          state   <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_COLLECT: begin
          if (bus.cancel || expired) begin
            // refund includes a coin landing now
            chg_v_q   <= (credit_in != '0);
            chg_amt_q <= credit_in;
            credit_q  <= '0;
            clear_q   <= 1'b1;
            state     <= S_IDLE;
            busy_q    <= 1'b0;
          end else begin
            credit_q <= credit_in;
            tmo <= bus.coin_valid ? '0
                                  : tmo + 1'b1;
            if (credit_q >= price_q)
              state <= S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          dispense_q <= 1'b1;
          dcode_q    <= code_q;
          state      <= S_CHANGE;
        end
        S_CHANGE: begin
          chg_v_q   <= (credit_q > price_q);
          chg_amt_q <= credit_q - price_q;
          credit_q  <= '0;
          clear_q   <= 1'b1;
          state     <= S_IDLE;
          busy_q    <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.clear         = clear_q;
  assign bus.dispense      = dispense_q;
  assign bus.dispense_code = dcode_q;
  assign bus.change_valid  = chg_v_q;
  assign bus.change_amount = chg_amt_q;
  assign bus.invalid_code  = inv_q;
  assign bus.coin_reject   = rej_q;
  assign bus.credit        = credit_q;
  assign bus.cycles        = cycles_q;

endmodule

// File: tb/tb_vend_machine_controller.sv
// Scoreboard bench for the vending
// controller with directed transactions.
module tb_vend_machine_controller;

  localparam int TMO    = 8;
  localparam int K_DISP = 0;
  localparam int K_CHG  = 1;
  localparam int K_INV  = 2;
  localparam int K_REJ  = 3;
  localparam int K_CLR  = 4;

  typedef struct {
    int kind;
    int val;
    int at;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   edges  = 0;
  int   s      = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  vend_machine_controller_if bus();

  vend_machine_controller #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  function automatic void push_ev(
    input int kind, input int val, input int at
  );
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    q.push_back(e);
  endfunction

  task automatic chk(
    input string nm, input int act, input int want
  );
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, want);
    end
  endtask

  task automatic mon(input int kind, input int val);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected strobe kind=%0d val=%0h edge=%0d",
               kind, val, edges);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.val != val
        || e.at != edges) begin
      errors++;
      $display("FAIL strobe: got kind=%0d val=%0h edge=%0d expected kind=%0d val=%0h edge=%0d",
               kind, val, edges, e.kind, e.val, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dispense)
      mon(K_DISP, int'(bus.dispense_code));
    if (bus.change_valid)
      mon(K_CHG, int'(bus.change_amount));
    if (bus.invalid_code) mon(K_INV, 0);
    if (bus.coin_reject)  mon(K_REJ, 0);
    if (bus.clear)        mon(K_CLR, 0);
  end

  task automatic drive(
    input logic        cp,
    input logic [11:0] code,
    input logic        cv,
    input logic [7:0]  val,
    input logic        cn
  );
    @(negedge clk);
    bus.check_price  = cp;
    bus.concat_press = code;
    bus.coin_valid   = cv;
    bus.coin_value   = val;
    bus.cancel       = cn;
    s = edges + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    int s0;
    logic [11:0] bad [3];
    bad = '{12'h009, 12'h0A1, 12'hA00};
    bus.check_price  = 1'b0;
    bus.concat_press = '0;
    bus.coin_valid   = 1'b0;
    bus.coin_value   = '0;
    bus.cancel       = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_flags", int'({bus.busy, bus.clear,
        bus.dispense, bus.change_valid,
        bus.invalid_code, bus.coin_reject}), 0);
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_amount", int'(bus.change_amount), 0);
    chk("rst_dcode", int'(bus.dispense_code), 0);
    chk("rst_cycles", int'(bus.cycles), 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    chk("cycles_run", int'(bus.cycles), 1);

    // exact payment 50+25 for row 1
    drive(1'b1, 12'h321, 1'b0, '0, 1'b0);
    s0 = s;
    push_ev(K_DISP, 'h321, s0 + 5);
    push_ev(K_CLR, 0, s0 + 6);
    idle(1);
    drive(1'b0, '0, 1'b1, 8'd50, 1'b0);
    drive(1'b0, '0, 1'b1, 8'd25, 1'b0);
    idle(1);
    chk("t1_credit", int'(bus.credit), 75);
    chk("t1_busy", int'(bus.busy), 1);
    idle(5);
    chk("t1_credit_end", int'(bus.credit), 0);
    chk("t1_busy_end", int'(bus.busy), 0);

    // row 7, 255 inserted, 55 change
    drive(1'b1, 12'h007, 1'b0, '0, 1'b0);
    s0 = s;
    push_ev(K_DISP, 'h007, s0 + 4);
    push_ev(K_CHG, 55, s0 + 5);
    push_ev(K_CLR, 0, s0 + 5);
    idle(1);
    drive(1'b0, '0, 1'b1, 8'd255, 1'b0);
    idle(1);
    chk("t2_credit", int'(bus.credit), 255);
    idle(5);
    chk("t2_credit_end", int'(bus.credit), 0);

    // rejected codes
    foreach (bad[i]) begin
      drive(1'b1, bad[i], 1'b0, '0, 1'b0);
      s0 = s;
      push_ev(K_INV, 0, s0 + 2);
      push_ev(K_CLR, 0, s0 + 2);
      idle(1);
      chk("inv_busy1", int'(bus.busy), 1);
      idle(1);
      chk("inv_busy2", int'(bus.busy), 1);
      idle(1);
      chk("inv_busy3", int'(bus.busy), 0);
    end

    // cancel together with a coin
    drive(1'b1, 12'h210, 1'b0, '0, 1'b0);
    s0 = s;
    push_ev(K_CHG, 35, s0 + 3);
    push_ev(K_CLR, 0, s0 + 3);
    idle(1);
    drive(1'b0, '0, 1'b1, 8'd25, 1'b0);
    drive(1'b0, '0, 1'b1, 8'd10, 1'b1);
    idle(1);
    chk("t4_credit", int'(bus.credit), 0);
    chk("t4_busy", int'(bus.busy), 0);
    idle(2);

    // saturating credit, row 6
    drive(1'b1, 12'h006, 1'b0, '0, 1'b0);
    s0 = s;
    push_ev(K_DISP, 'h006, s0 + 5);
    push_ev(K_CHG, 105, s0 + 6);
    push_ev(K_CLR, 0, s0 + 6);
    idle(1);
    drive(1'b0, '0, 1'b1, 8'd100, 1'b0);
    drive(1'b0, '0, 1'b1, 8'd200, 1'b0);
    idle(1);
    chk("sat_credit", int'(bus.credit), 255);
    idle(5);

    // cancel with no credit
    drive(1'b1, 12'h003, 1'b0, '0, 1'b0);
    s0 = s;
    push_ev(K_CLR, 0, s0 + 2);
    idle(1);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle(2);
    chk("c0_busy", int'(bus.busy), 0);

    // inactivity timeout refund
    drive(1'b1, 12'h100, 1'b0, '0, 1'b0);
    s0 = s;
    push_ev(K_CHG, 25, s0 + 10);
    push_ev(K_CLR, 0, s0 + 10);
    idle(1);
    drive(1'b0, '0, 1'b1, 8'd25, 1'b0);
    idle(7);
    chk("tmo_busy_pre", int'(bus.busy), 1);
    chk("tmo_credit_pre", int'(bus.credit), 25);
    idle(3);
    chk("tmo_busy", int'(bus.busy), 0);
    chk("tmo_credit", int'(bus.credit), 0);

    // coin and cancel while idle
    drive(1'b0, '0, 1'b1, 8'd30, 1'b0);
    push_ev(K_REJ, 0, s);
    idle(1);
    chk("rej_credit", int'(bus.credit), 0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle(2);
    chk("idle_cancel_busy", int'(bus.busy), 0);

    // reset in the middle of collection
    drive(1'b1, 12'h000, 1'b0, '0, 1'b0);
    idle(1);
    drive(1'b0, '0, 1'b1, 8'd40, 1'b0);
    idle(1);
    chk("mid_credit", int'(bus.credit), 40);
    chk("mid_busy", int'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_flags", int'({bus.busy, bus.clear,
        bus.dispense, bus.change_valid,
        bus.invalid_code, bus.coin_reject}), 0);
    chk("mid_rst_credit", int'(bus.credit), 0);
    chk("mid_rst_cycles", int'(bus.cycles), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // resumes after reset
    drive(1'b1, 12'h009, 1'b0, '0, 1'b0);
    s0 = s;
    push_ev(K_INV, 0, s0 + 2);
    push_ev(K_CLR, 0, s0 + 2);
    idle(4);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
